// File: rtl/mm_mem_responder.sv
// mm_mem_responder
// Per-lane operand and result memories shared between a host loader, N
// independent compute lanes (read operands, write results) and an ordered
// drain port that streams every lane's results back once all lanes finish.
module mm_mem_responder #(
    parameter  int N          = 4,
    parameter  int DW         = 2,
    parameter  int BRAM_DEPTH = 32,
    localparam int AW         = $clog2(BRAM_DEPTH),
    localparam int LW         = $clog2(N),
    localparam int RW         = 2*DW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [LW-1:0]        ld_lane,
    input  logic [AW-1:0]        ld_addr,
    input  logic [DW-1:0]        ld_data,

    input  logic                 start,
    input  logic [AW:0]          res_count,
    output logic                 busy,
    output logic                 done,

    input  logic                 mem_rd_en [0:N-1],
    input  logic [AW-1:0]        rd_addr   [0:N-1],
    output logic [DW-1:0]        rd_data   [0:N-1],
    output logic                 rd_valid  [0:N-1],

    input  logic                 mem_wr_en [0:N-1],
    input  logic [AW-1:0]        wr_addr   [0:N-1],
    input  logic [RW-1:0]        result    [0:N-1],

    output logic                 dr_valid,
    input  logic                 dr_ready,
    output logic [RW-1:0]        dr_data,
    output logic [LW-1:0]        dr_lane,
    output logic [AW-1:0]        dr_addr,
    output logic                 dr_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;
    logic [AW:0]    rc_q;
    logic [AW:0]    lane_cnt [0:N-1];
    logic           all_done;

    logic [DW-1:0]  op_mem  [0:N-1][0:BRAM_DEPTH-1];
    logic [RW-1:0]  res_mem [0:N-1][0:BRAM_DEPTH-1];

    // Drain read pointer: the next (lane, addr) to fetch from result memory.
    logic [LW-1:0]  ptr_lane;
    logic [AW-1:0]  ptr_addr;
    logic           ptr_active;
    logic           ptr_end_addr;
    logic           ptr_end_lane;

    // Fetch stage holding the word read out of result memory.
    logic           s1_valid;
    logic [RW-1:0]  s1_data;
    logic [LW-1:0]  s1_lane;
    logic [AW-1:0]  s1_addr;
    logic           s1_last;

    logic           out_en;
    logic           s1_en;
    logic           issue;
    logic           xfer_last;

    assign ld_ready     = (state == IDLE);
    assign busy         = (state != IDLE);

    assign ptr_end_addr = ({1'b0, ptr_addr} == (rc_q - (AW+1)'(1)));
    assign ptr_end_lane = (ptr_lane == LW'(N-1));

    // The output register may take a new word when empty or being accepted;
    // the fetch stage may refill whenever its word moves on.
    assign out_en       = !dr_valid || dr_ready;
    assign s1_en        = !s1_valid || out_en;
    assign issue        = (state == DRAIN) && ptr_active && s1_en;
    assign xfer_last    = dr_valid && dr_ready && dr_last;

    // Run completes once every lane has reported res_count result writes.
    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (lane_cnt[i] != rc_q) begin
                all_done = 1'b0;
            end
        end
    end

    // Main control FSM: start latching, run completion, drain pointer and done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rc_q       <= '0;
            done       <= 1'b0;
            ptr_lane   <= '0;
            ptr_addr   <= '0;
            ptr_active <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        rc_q  <= res_count;
                    end
                end
                RUN: begin
                    if (all_done) begin
                        if (rc_q == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state      <= DRAIN;
                            ptr_lane   <= '0;
                            ptr_addr   <= '0;
                            ptr_active <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        if (ptr_end_addr) begin
                            ptr_addr <= '0;
                            if (ptr_end_lane) begin
                                ptr_active <= 1'b0;
                            end else begin
                                ptr_lane <= ptr_lane + LW'(1);
                            end
                        end else begin
                            ptr_addr <= ptr_addr + AW'(1);
                        end
                    end
                    if (xfer_last) begin
                        state      <= IDLE;
                        done       <= 1'b1;
                        ptr_active <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-lane result counters, cleared on start and saturating at the latched count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                lane_cnt[i] <= '0;
            end else if (state == IDLE && start) begin
                lane_cnt[i] <= '0;
            end else if (state == RUN && mem_wr_en[i] && lane_cnt[i] != rc_q) begin
                lane_cnt[i] <= lane_cnt[i] + (AW+1)'(1);
            end
        end
    end

    // Host loads land in operand memory only while idle.
    always_ff @(posedge clk) begin
        if (rst && ld_valid && ld_ready) begin
            op_mem[ld_lane][ld_addr] <= ld_data;
        end
    end

    // Lane result writes are accepted only during a run; duplicates simply overwrite.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst && state == RUN && mem_wr_en[i]) begin
                res_mem[i][wr_addr[i]] <= result[i];
            end
        end
    end

    // Lane operand read data, one-cycle latency, memory-style port without reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (state == RUN && mem_rd_en[i]) begin
                rd_data[i] <= op_mem[i][rd_addr[i]];
            end
        end
    end

    // Lane read valid flags track reads accepted in the previous cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                rd_valid[i] <= 1'b0;
            end else begin
                rd_valid[i] <= (state == RUN) && mem_rd_en[i];
            end
        end
    end

    // Result memory read for the drain fetch stage, kept free of reset for BRAM mapping.
    always_ff @(posedge clk) begin
        if (issue) begin
            s1_data <= res_mem[ptr_lane][ptr_addr];
        end
    end

    // Two-stage drain pipeline with a common stall so outputs hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_lane  <= '0;
            s1_addr  <= '0;
            s1_last  <= 1'b0;
            dr_valid <= 1'b0;
            dr_data  <= '0;
            dr_lane  <= '0;
            dr_addr  <= '0;
            dr_last  <= 1'b0;
        end else if (state != DRAIN) begin
            s1_valid <= 1'b0;
            dr_valid <= 1'b0;
            dr_last  <= 1'b0;
        end else begin
            if (out_en) begin
                dr_valid <= s1_valid;
                dr_data  <= s1_data;
                dr_lane  <= s1_lane;
                dr_addr  <= s1_addr;
                dr_last  <= s1_valid && s1_last;
            end
            if (s1_en) begin
                s1_valid <= issue;
                s1_lane  <= ptr_lane;
                s1_addr  <= ptr_addr;
                s1_last  <= ptr_end_addr && ptr_end_lane;
            end
        end
    end

endmodule

// File: tb/tb_mm_mem_responder.sv
// tb_mm_mem_responder
// Randomized self-checking bench. Operand and result memories are modelled as
// plain arrays; drained words are checked against the ordering rule
// (lane-major, address-minor) computed directly from those arrays.
module tb_mm_mem_responder;

    localparam int N          = 4;
    localparam int DW         = 2;
    localparam int BRAM_DEPTH = 32;
    localparam int AW         = $clog2(BRAM_DEPTH);
    localparam int LW         = $clog2(N);
    localparam int RW         = 2*DW + $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ld_valid;
    logic           ld_ready;
    logic [LW-1:0]  ld_lane;
    logic [AW-1:0]  ld_addr;
    logic [DW-1:0]  ld_data;
    logic           start;
    logic [AW:0]    res_count;
    logic           busy;
    logic           done;
    logic           mem_rd_en [0:N-1];
    logic [AW-1:0]  rd_addr   [0:N-1];
    logic [DW-1:0]  rd_data   [0:N-1];
    logic           rd_valid  [0:N-1];
    logic           mem_wr_en [0:N-1];
    logic [AW-1:0]  wr_addr   [0:N-1];
    logic [RW-1:0]  result    [0:N-1];
    logic           dr_valid;
    logic           dr_ready;
    logic [RW-1:0]  dr_data;
    logic [LW-1:0]  dr_lane;
    logic [AW-1:0]  dr_addr;
    logic           dr_last;

    always #5 clk = ~clk;

    mm_mem_responder #(.N(N), .DW(DW), .BRAM_DEPTH(BRAM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_lane(ld_lane),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .res_count(res_count), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_wr_en(mem_wr_en), .wr_addr(wr_addr), .result(result),
        .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_data(dr_data),
        .dr_lane(dr_lane), .dr_addr(dr_addr), .dr_last(dr_last)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model of the memories and the latched result count.
    logic [DW-1:0] op_model  [N][BRAM_DEPTH];
    logic [RW-1:0] res_model [N][BRAM_DEPTH];
    int            rc_model;

    // Words observed on the drain port during the latest collection.
    logic [RW-1:0] cap_data [$];
    int            cap_lane [$];
    int            cap_addr [$];
    bit            cap_last [$];
    int            cap_done;
    int            cap_hold_err;
    int            cap_first_valid;
    int            cap_first_xfer;
    int            cap_last_xfer;
    bit            cap_timeout;

    // Safety net in case a wait somewhere never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        ld_lane   = '0;
        ld_addr   = '0;
        ld_data   = '0;
        start     = 1'b0;
        res_count = '0;
        dr_ready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem_rd_en[i] = 1'b0;
            rd_addr[i]   = '0;
            mem_wr_en[i] = 1'b0;
            wr_addr[i]   = '0;
            result[i]    = '0;
        end
    endtask

    task automatic load_op(input int lane, input int addr, input logic [DW-1:0] data);
        ld_valid = 1'b1;
        ld_lane  = LW'(lane);
        ld_addr  = AW'(addr);
        ld_data  = data;
        step();
        ld_valid = 1'b0;
        op_model[lane][addr] = data;
    endtask

    task automatic start_run(input int rc);
        start     = 1'b1;
        res_count = (AW+1)'(rc);
        step();
        start     = 1'b0;
        rc_model  = rc;
    endtask

    // Applies the lane write inputs already set up for one cycle; updates the model when effective.
    task automatic commit_writes(input bit effective);
        if (effective) begin
            for (int i = 0; i < N; i++) begin
                if (mem_wr_en[i]) res_model[i][wr_addr[i]] = result[i];
            end
        end
        step();
        for (int i = 0; i < N; i++) mem_wr_en[i] = 1'b0;
    endtask

    // Fills every lane with rc addresses of random results in ascending address order.
    task automatic write_full_random(input int rc);
        for (int a = 0; a < rc; a++) begin
            for (int i = 0; i < N; i++) begin
                mem_wr_en[i] = 1'b1;
                wr_addr[i]   = AW'(a);
                result[i]    = RW'($urandom);
            end
            commit_writes(1'b1);
        end
    endtask

    // Records drain traffic until a done pulse plus a few quiet cycles; mode 0 ready high,
    // mode 1 ready pattern 1,0,0,1, mode 2 random ready.
    task automatic collect_drain(input int mode, input int budget);
        bit            prev_stall;
        bit            r;
        int            after_done;
        logic [RW-1:0] h_data;
        logic [LW-1:0] h_lane;
        logic [AW-1:0] h_addr;
        logic          h_last;
        cap_data.delete(); cap_lane.delete(); cap_addr.delete(); cap_last.delete();
        cap_done = 0; cap_hold_err = 0; cap_first_valid = -1;
        cap_first_xfer = -1; cap_last_xfer = -1; cap_timeout = 1'b1;
        prev_stall = 1'b0; after_done = -1;
        h_data = '0; h_lane = '0; h_addr = '0; h_last = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) begin
                cap_done++;
                if (after_done < 0) after_done = c;
            end
            if (prev_stall && (dr_valid !== 1'b1 || dr_data !== h_data || dr_lane !== h_lane ||
                               dr_addr !== h_addr || dr_last !== h_last)) cap_hold_err++;
            if (dr_valid === 1'b1 && cap_first_valid < 0) cap_first_valid = c;
            case (mode)
                0:       r = 1'b1;
                1:       r = ((c % 4) == 0) || ((c % 4) == 3);
                default: r = 1'($urandom % 2);
            endcase
            dr_ready = r;
            if (dr_valid === 1'b1 && r) begin
                cap_data.push_back(dr_data);
                cap_lane.push_back(int'(dr_lane));
                cap_addr.push_back(int'(dr_addr));
                cap_last.push_back(dr_last);
                if (cap_first_xfer < 0) cap_first_xfer = c;
                cap_last_xfer = c;
            end
            prev_stall = (dr_valid === 1'b1) && !r;
            h_data = dr_data; h_lane = dr_lane; h_addr = dr_addr; h_last = dr_last;
            if (after_done >= 0 && c >= after_done + 3) begin
                cap_timeout = 1'b0;
                break;
            end
            step();
        end
        dr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (dr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dr_valid: got %0b want 0", dr_valid); end
        n_cmp++; if (dr_last !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_dr_last: got %0b want 0", dr_last); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ld_ready: got %0b want 1", ld_ready); end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (rd_valid[i] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid%0d: got %0b want 0", i, rd_valid[i]); end
        end
        rst = 1'b1;
        step();
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ld_ready: got %0b want 1", ld_ready); end
    endtask

    task automatic test_operand_read();
        bit            exp_en [N];
        logic [DW-1:0] exp_d  [N];
        for (int l = 0; l < N; l++)
            for (int a = 0; a < BRAM_DEPTH; a++) load_op(l, a, DW'($urandom));
        load_op(2, 5, 2'd3);
        start_run(1);
        n_cmp++; if (busy !== 1'b1)     begin n_fail++; $display("[TB] FAIL run_busy: got %0b want 1", busy); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL run_ld_ready: got %0b want 0", ld_ready); end
        // Directed single-lane read.
        mem_rd_en[2] = 1'b1;
        rd_addr[2]   = AW'(5);
        step();
        mem_rd_en[2] = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (rd_valid[i] !== (i == 2)) begin n_fail++; $display("[TB] FAIL read_direct_valid%0d: got %0b want %0b", i, rd_valid[i], (i == 2)); end
        end
        n_cmp++; if (rd_data[2] !== 2'd3) begin n_fail++; $display("[TB] FAIL read_direct_data: got %0d want 3", rd_data[2]); end
        // Random independent reads on all lanes.
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                exp_en[i]    = 1'($urandom % 2);
                mem_rd_en[i] = exp_en[i];
                rd_addr[i]   = AW'($urandom_range(0, BRAM_DEPTH-1));
                exp_d[i]     = op_model[i][rd_addr[i]];
            end
            step();
            for (int i = 0; i < N; i++) begin
                mem_rd_en[i] = 1'b0;
                n_cmp++;
                if (rd_valid[i] !== exp_en[i]) begin n_fail++; $display("[TB] FAIL read_rand_valid c%0d l%0d: got %0b want %0b", c, i, rd_valid[i], exp_en[i]); end
                if (exp_en[i]) begin
                    n_cmp++;
                    if (rd_data[i] !== exp_d[i]) begin n_fail++; $display("[TB] FAIL read_rand_data c%0d l%0d: got %0d want %0d", c, i, rd_data[i], exp_d[i]); end
                end
            end
        end
        write_full_random(1);
        collect_drain(2, 300);
        n_cmp++;
        if (cap_timeout || cap_data.size() != N*rc_model) begin n_fail++; $display("[TB] FAIL read_run_words: got %0d (timeout %0b) want %0d", cap_data.size(), cap_timeout, N*rc_model); end
        for (int k = 0; k < cap_data.size() && k < N*rc_model; k++) begin
            int el = k / rc_model;
            int ea = k % rc_model;
            n_cmp++;
            if (cap_lane[k] != el || cap_addr[k] != ea || cap_data[k] !== res_model[el][ea] || cap_last[k] != (k == N*rc_model-1)) begin
                n_fail++; $display("[TB] FAIL read_run_word%0d: got l%0d a%0d d%0d last%0b want l%0d a%0d d%0d last%0b", k, cap_lane[k], cap_addr[k], cap_data[k], cap_last[k], el, ea, res_model[el][ea], (k == N*rc_model-1));
            end
        end
        n_cmp++; if (cap_done != 1) begin n_fail++; $display("[TB] FAIL read_run_done: got %0d pulses want 1", cap_done); end
    endtask

    task automatic test_drain_order();
        start_run(2);
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < N; i++) begin
                mem_wr_en[i] = 1'b1;
                wr_addr[i]   = AW'(a);
                result[i]    = RW'(10*i + a);
            end
            commit_writes(1'b1);
        end
        collect_drain(0, 200);
        n_cmp++;
        if (cap_timeout || cap_data.size() != 8) begin n_fail++; $display("[TB] FAIL order_words: got %0d (timeout %0b) want 8", cap_data.size(), cap_timeout); end
        for (int k = 0; k < cap_data.size() && k < 8; k++) begin
            int el = k / 2;
            int ea = k % 2;
            n_cmp++;
            if (cap_lane[k] != el || cap_addr[k] != ea || cap_data[k] !== RW'(10*el + ea) || cap_last[k] != (k == 7)) begin
                n_fail++; $display("[TB] FAIL order_word%0d: got l%0d a%0d d%0d last%0b want l%0d a%0d d%0d last%0b", k, cap_lane[k], cap_addr[k], cap_data[k], cap_last[k], el, ea, 10*el + ea, (k == 7));
            end
        end
        n_cmp++; if (cap_done != 1) begin n_fail++; $display("[TB] FAIL order_done: got %0d pulses want 1", cap_done); end
        n_cmp++;
        if (cap_first_valid < 0 || cap_first_valid > 3) begin n_fail++; $display("[TB] FAIL order_first_valid: got cycle %0d want 0..3", cap_first_valid); end
        n_cmp++;
        if (cap_last_xfer - cap_first_xfer != 7) begin n_fail++; $display("[TB] FAIL order_throughput: got span %0d want 7", cap_last_xfer - cap_first_xfer); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL order_idle_busy: got %0b want 0", busy); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL order_idle_ld_ready: got %0b want 1", ld_ready); end
    endtask

    task automatic test_backpressure();
        // Full run drained with the 1,0,0,1 ready pattern.
        start_run(3);
        write_full_random(3);
        collect_drain(1, 300);
        n_cmp++;
        if (cap_timeout || cap_data.size() != N*3) begin n_fail++; $display("[TB] FAIL bp_words: got %0d (timeout %0b) want %0d", cap_data.size(), cap_timeout, N*3); end
        for (int k = 0; k < cap_data.size() && k < N*3; k++) begin
            int el = k / 3;
            int ea = k % 3;
            n_cmp++;
            if (cap_lane[k] != el || cap_addr[k] != ea || cap_data[k] !== res_model[el][ea] || cap_last[k] != (k == N*3-1)) begin
                n_fail++; $display("[TB] FAIL bp_word%0d: got l%0d a%0d d%0d last%0b want l%0d a%0d d%0d", k, cap_lane[k], cap_addr[k], cap_data[k], cap_last[k], el, ea, res_model[el][ea]);
            end
        end
        n_cmp++; if (cap_hold_err != 0) begin n_fail++; $display("[TB] FAIL bp_hold: got %0d unstable stalls want 0", cap_hold_err); end
        n_cmp++; if (cap_done != 1)     begin n_fail++; $display("[TB] FAIL bp_done: got %0d pulses want 1", cap_done); end
        // Second run: duplicate address wins last and still counts; address 2 persists.
        start_run(3);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                mem_wr_en[i] = 1'b1;
                wr_addr[i]   = AW'((c < 2) ? 1 : 0);
                result[i]    = RW'($urandom);
            end
            commit_writes(1'b1);
        end
        collect_drain(2, 400);
        n_cmp++;
        if (cap_timeout || cap_data.size() != N*3) begin n_fail++; $display("[TB] FAIL dup_words: got %0d (timeout %0b) want %0d", cap_data.size(), cap_timeout, N*3); end
        for (int k = 0; k < cap_data.size() && k < N*3; k++) begin
            int el = k / 3;
            int ea = k % 3;
            n_cmp++;
            if (cap_lane[k] != el || cap_addr[k] != ea || cap_data[k] !== res_model[el][ea] || cap_last[k] != (k == N*3-1)) begin
                n_fail++; $display("[TB] FAIL dup_word%0d: got l%0d a%0d d%0d last%0b want l%0d a%0d d%0d", k, cap_lane[k], cap_addr[k], cap_data[k], cap_last[k], el, ea, res_model[el][ea]);
            end
        end
        n_cmp++; if (cap_hold_err != 0) begin n_fail++; $display("[TB] FAIL dup_hold: got %0d unstable stalls want 0", cap_hold_err); end
    endtask

    task automatic test_zero_count();
        start_run(0);
        collect_drain(0, 50);
        n_cmp++; if (cap_timeout)           begin n_fail++; $display("[TB] FAIL zero_timeout: got no done want done"); end
        n_cmp++; if (cap_first_valid >= 0)  begin n_fail++; $display("[TB] FAIL zero_dr_valid: got dr_valid at cycle %0d want never", cap_first_valid); end
        n_cmp++; if (cap_done != 1)         begin n_fail++; $display("[TB] FAIL zero_done: got %0d pulses want 1", cap_done); end
        n_cmp++; if (ld_ready !== 1'b1)     begin n_fail++; $display("[TB] FAIL zero_ld_ready: got %0b want 1", ld_ready); end
    endtask

    task automatic test_reset_mid_drain();
        int xfers;
        start_run(2);
        write_full_random(2);
        xfers = 0;
        dr_ready = 1'b1;
        for (int c = 0; c < 50 && xfers < 3; c++) begin
            if (dr_valid === 1'b1) xfers++;
            step();
        end
        n_cmp++; if (xfers != 3) begin n_fail++; $display("[TB] FAIL rstmid_xfers: got %0d want 3", xfers); end
        rst = 1'b0;
        step();
        n_cmp++; if (dr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_dr_valid: got %0b want 0", dr_valid); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL rstmid_busy: got %0b want 0", busy); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ld_ready: got %0b want 1", ld_ready); end
        n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("[TB] FAIL rstmid_done: got %0b want 0", done); end
        rst = 1'b1;
        dr_ready = 1'b0;
        step();
        start_run(2);
        write_full_random(2);
        collect_drain(0, 200);
        n_cmp++;
        if (cap_timeout || cap_data.size() != N*2) begin n_fail++; $display("[TB] FAIL rstmid_rerun_words: got %0d (timeout %0b) want %0d", cap_data.size(), cap_timeout, N*2); end
        for (int k = 0; k < cap_data.size() && k < N*2; k++) begin
            int el = k / 2;
            int ea = k % 2;
            n_cmp++;
            if (cap_lane[k] != el || cap_addr[k] != ea || cap_data[k] !== res_model[el][ea] || cap_last[k] != (k == N*2-1)) begin
                n_fail++; $display("[TB] FAIL rstmid_rerun_word%0d: got l%0d a%0d d%0d want l%0d a%0d d%0d", k, cap_lane[k], cap_addr[k], cap_data[k], el, ea, res_model[el][ea]);
            end
        end
        n_cmp++; if (cap_done != 1) begin n_fail++; $display("[TB] FAIL rstmid_rerun_done: got %0d pulses want 1", cap_done); end
    endtask

    task automatic test_ignored();
        logic [DW-1:0] keep;
        keep = DW'($urandom);
        load_op(0, 0, keep);
        // Reads while idle must not produce valid data.
        for (int i = 0; i < N; i++) mem_rd_en[i] = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            mem_rd_en[i] = 1'b0;
            n_cmp++;
            if (rd_valid[i] !== 1'b0) begin n_fail++; $display("[TB] FAIL ign_idle_read%0d: got %0b want 0", i, rd_valid[i]); end
        end
        // Writes while idle must not reach result memory.
        for (int i = 0; i < N; i++) begin
            mem_wr_en[i] = 1'b1;
            wr_addr[i]   = '0;
            result[i]    = ~res_model[i][0];
        end
        commit_writes(1'b0);
        start_run(2);
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ign_run_ld_ready: got %0b want 0", ld_ready); end
        // Load attempt and a second start during the run are both ignored.
        ld_valid = 1'b1; ld_lane = '0; ld_addr = '0; ld_data = ~keep;
        start = 1'b1; res_count = (AW+1)'(5);
        step();
        ld_valid = 1'b0; start = 1'b0;
        mem_rd_en[0] = 1'b1; rd_addr[0] = '0;
        step();
        mem_rd_en[0] = 1'b0;
        n_cmp++; if (rd_valid[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_read_valid: got %0b want 1", rd_valid[0]); end
        n_cmp++; if (rd_data[0] !== keep)  begin n_fail++; $display("[TB] FAIL ign_run_load: got %0d want %0d", rd_data[0], keep); end
        // Fill only address 1 twice so address 0 shows the pre-idle contents.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) begin
                mem_wr_en[i] = 1'b1;
                wr_addr[i]   = AW'(1);
                result[i]    = RW'($urandom);
            end
            commit_writes(1'b1);
        end
        collect_drain(0, 200);
        n_cmp++;
        if (cap_timeout || cap_data.size() != N*2) begin n_fail++; $display("[TB] FAIL ign_words: got %0d (timeout %0b) want %0d", cap_data.size(), cap_timeout, N*2); end
        for (int k = 0; k < cap_data.size() && k < N*2; k++) begin
            int el = k / 2;
            int ea = k % 2;
            n_cmp++;
            if (cap_lane[k] != el || cap_addr[k] != ea || cap_data[k] !== res_model[el][ea] || cap_last[k] != (k == N*2-1)) begin
                n_fail++; $display("[TB] FAIL ign_word%0d: got l%0d a%0d d%0d want l%0d a%0d d%0d", k, cap_lane[k], cap_addr[k], cap_data[k], el, ea, res_model[el][ea]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_operand_read();
        test_drain_order();
        test_backpressure();
        test_zero_count();
        test_reset_mid_drain();
        test_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_mem_responder.md
MM_MEM_RESPONDER -- requirements
Module: mm_mem_responder

Interface
REQ-001 SHALL have parameters: N, default 4, lane count; DW, default 2, operand width; BRAM_DEPTH, default 32, words per lane memory. Derived: AW = $clog2(BRAM_DEPTH), LW = $clog2(N), RW = 2*DW + $clog2(N).
REQ-002 SHALL have one clock and a synchronous active-low reset: clk  in  1  clock, all state on rising edge; rst  in  1  synchronous reset, active-low.
REQ-003 SHALL have host load ports: ld_valid in 1; ld_ready out 1; ld_lane in LW; ld_addr in AW; ld_data in DW (operand word).
REQ-004 SHALL have control ports: start in 1 (begin run); res_count in AW+1 (result words expected per lane); busy out 1; done out 1 (one-cycle completion pulse).
REQ-005 SHALL have lane read ports (arrays [0:N-1]): mem_rd_en in 1; rd_addr in AW; rd_data out DW; rd_valid out 1.
REQ-006 SHALL have lane write ports (arrays [0:N-1]): mem_wr_en in 1; wr_addr in AW; result in RW.
REQ-007 SHALL have drain ports: dr_valid out 1; dr_ready in 1; dr_data out RW; dr_lane out LW; dr_addr out AW; dr_last out 1.

Function
REQ-008 SHALL hold per lane an operand memory (BRAM_DEPTH x DW) and a result memory (BRAM_DEPTH x RW).
REQ-009 SHALL implement FSM states IDLE, RUN, DRAIN; busy = 1 in RUN or DRAIN.
REQ-010 SHALL drive ld_ready = 1 only in IDLE; a load SHALL write ld_data to operand[ld_lane][ld_addr] when ld_valid && ld_ready.
REQ-011 SHALL move IDLE -> RUN on start, latching res_count and clearing all lane write counters; start outside IDLE SHALL be ignored.
REQ-012 SHALL, with latched res_count = 0, go IDLE -> RUN -> IDLE, skip DRAIN, and pulse done the cycle after leaving RUN.
REQ-013 In RUN, mem_rd_en[i] at cycle t SHALL yield rd_valid[i] = 1 and rd_data[i] = operand[i][rd_addr[i]] at t+1 (fixed 1-cycle latency, one read per lane per cycle, lanes independent).
REQ-014 rd_valid[i] SHALL be 0 in any cycle not following an accepted read; mem_rd_en outside RUN SHALL be ignored.
REQ-015 In RUN, mem_wr_en[i] SHALL write result[i] to result-memory[i][wr_addr[i]] and increment lane counter i, saturating at res_count; a duplicate address overwrites (last wins) and still counts.
REQ-016 mem_wr_en outside RUN SHALL be ignored (no write, no count).
REQ-017 SHALL move RUN -> DRAIN the cycle after every lane counter equals res_count.
REQ-018 DRAIN SHALL emit words in order lane 0..N-1, address 0..res_count-1 within each lane, with dr_lane/dr_addr identifying each word.
REQ-019 dr_valid, dr_data, dr_lane, dr_addr, dr_last SHALL stay stable while dr_valid && !dr_ready; a word is transferred when dr_valid && dr_ready.
REQ-020 With dr_ready held high, DRAIN SHALL sustain one word per cycle after the first dr_valid; first dr_valid SHALL assert no more than 2 cycles after entering DRAIN.
REQ-021 dr_last SHALL be 1 only on lane N-1, address res_count-1; its transfer SHALL return FSM to IDLE and pulse done for exactly one cycle on the next cycle.
REQ-022 Memory contents SHALL persist across runs; only counters and FSM are cleared by start.

Reset
REQ-023 rst = 0 at a rising edge SHALL force IDLE and set busy, done, dr_valid, dr_last, all rd_valid to 0 and ld_ready to 1, from any state including mid-RUN or mid-DRAIN.
REQ-024 Reset SHALL clear counters and the latched res_count; memory contents are undefined after reset and SHALL NOT be relied on.
REQ-025 rd_data, dr_data, dr_lane, dr_addr values are don't-care while their valid is 0.

Verification
REQ-026 N=4, DW=2: load operand[2][5]=3, start, res_count=1, mem_rd_en[2]=1, rd_addr[2]=5 -> next cycle rd_valid[2]=1, rd_data[2]=3, other rd_valid=0.
REQ-027 res_count=2, each lane writes addr 0,1 with result = 10*lane+addr -> DRAIN emits 0,1,10,11,20,21,30,31 in order, dr_last only on 31, done pulses once, then IDLE.
REQ-028 During DRAIN toggle dr_ready 1,0,0,1 -> outputs frozen during low cycles, no word lost or duplicated.
REQ-029 start with res_count=0 -> no dr_valid ever, done pulses once, ld_ready returns to 1.
REQ-030 rst=0 mid-DRAIN after 3 transfers -> next cycle dr_valid=0, busy=0, ld_ready=1; new start runs normally.
REQ-031 mem_wr_en in IDLE and loads with ld_valid in RUN -> no write, no count, ld_ready=0 in RUN.
